// File: rtl/sq_pkg.sv
// Shared definitions for the squared-sample energy path: sample width,
// largest legal squared value, accumulator FSM states, width helper.
package sq_pkg;

    localparam int SQ_W   = 10;
    localparam int SQ_MAX = 961;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        HOLD = 1'b1
    } sq_acc_state_t;

    // Accumulator width that holds BLK_LEN full-scale squares.
    function automatic int acc_width(input int blk_len);
        return SQ_W + $clog2(blk_len);
    endfunction

endpackage

// File: rtl/sq_result_reg.sv
// Output holding register with valid/ready: load captures d and raises
// valid, d is held while valid & !ready, valid & ready clears valid.
// Ports: clk, rst (sync, active high), load, d, ready -> valid, q.
module sq_result_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= d;
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign q     = r_data;

endmodule

// File: rtl/sq_energy_accum.sv
// Sum-of-squares block accumulator: adds BLK_LEN squared samples (or a
// flushed partial block) and presents sum/count on a valid/ready port.
// Ports: clk, rst (sync, active high), sq_in/sq_valid/sq_ready in,
// flush, out_sum/out_cnt/out_valid/out_ready result port.
// Optional macro SQ_ENERGY_PEAK_EN adds out_peak, the block maximum.
module sq_energy_accum
    import sq_pkg::*;
#(
    parameter int BLK_LEN = 16,
    parameter int CNT_W   = $clog2(BLK_LEN + 1),
    parameter int ACC_W   = acc_width(BLK_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SQ_W-1:0]  sq_in,
    input  logic             sq_valid,
    output logic             sq_ready,
    input  logic             flush,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SQ_ENERGY_PEAK_EN
    ,
    output logic [SQ_W-1:0]  out_peak
`endif
);

    if (BLK_LEN < 2 || BLK_LEN > 256) begin : g_bad_len
        $error("sq_energy_accum: BLK_LEN out of range 2..256");
    end

    if (longint'(SQ_MAX) * longint'(BLK_LEN) >=
        (longint'(1) << ACC_W)) begin : g_ovf
        $error("sq_energy_accum: ACC_W too narrow for full block");
    end

`ifdef SQ_ENERGY_PEAK_EN
    localparam int PAY_W = ACC_W + CNT_W + SQ_W;
`else
    localparam int PAY_W = ACC_W + CNT_W;
`endif

    sq_acc_state_t    r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_acc;
    logic             w_accept;
    logic [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_full;
    logic             w_flush_go;
    logic             w_close;
    logic [PAY_W-1:0] w_res_d;
    logic [PAY_W-1:0] w_res_q;

    assign w_in_acc = (r_state == ACC);
    assign sq_ready = w_in_acc;
    assign w_accept = sq_valid & w_in_acc;

    assign w_acc_next = w_accept ? r_acc + ACC_W'(sq_in) : r_acc;
    assign w_cnt_next = r_cnt + CNT_W'(w_accept);

    assign w_full = w_accept && (r_cnt == CNT_W'(BLK_LEN - 1));

    // An empty flush (no stored and no same-cycle sample) is ignored.
    assign w_flush_go = w_in_acc && flush && (w_cnt_next != '0);
    assign w_close    = w_full | w_flush_go;

`ifdef SQ_ENERGY_PEAK_EN
    logic [SQ_W-1:0] r_peak;
    logic [SQ_W-1:0] w_peak_next;

    assign w_peak_next = (w_accept && sq_in > r_peak) ? sq_in : r_peak;
    assign w_res_d     = {w_acc_next, w_cnt_next, w_peak_next};
    assign {out_sum, out_cnt, out_peak} = w_res_q;

    always_ff @(posedge clk) begin
        if (rst || (w_in_acc && w_close)) begin
            r_peak <= '0;
        end else if (w_in_acc) begin
            r_peak <= w_peak_next;
        end
    end
`else
    assign w_res_d = {w_acc_next, w_cnt_next};
    assign {out_sum, out_cnt} = w_res_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_close) begin
                        r_state <= HOLD;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        r_state <= ACC;
                    end
                end
                default: r_state <= ACC;
            endcase
        end
    end

    sq_result_reg #(
        .DATA_W(PAY_W)
    ) u_result (
        .clk  (clk),
        .rst  (rst),
        .load (w_close),
        .d    (w_res_d),
        .ready(out_ready),
        .valid(out_valid),
        .q    (w_res_q)
    );

endmodule

// File: tb/tb_sq_energy_accum.sv
// Self-checking bench for sq_energy_accum: directed scenarios plus
// random traffic against a queue-based block model.
module tb_sq_energy_accum;

    localparam int BLK   = 16;
    localparam int CNT_W = $clog2(BLK + 1);
    localparam int ACC_W = 10 + $clog2(BLK);

    logic             clk = 1'b0;
    logic             rst;
    logic [9:0]       sq_in;
    logic             sq_valid;
    logic             sq_ready;
    logic             flush;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_cnt;
    logic             out_valid;
    logic             out_ready;
`ifdef SQ_ENERGY_PEAK_EN
    logic [9:0]       out_peak;
`endif

    always #5 clk = ~clk;

    sq_energy_accum #(
        .BLK_LEN(BLK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sq_in    (sq_in),
        .sq_valid (sq_valid),
        .sq_ready (sq_ready),
        .flush    (flush),
        .out_sum  (out_sum),
        .out_cnt  (out_cnt),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef SQ_ENERGY_PEAK_EN
        ,
        .out_peak (out_peak)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Behavioural model: samples of the open block kept in a queue.
    int  m_blk[$];
    bit  m_hold;
    bit  m_valid;
    int  m_osum;
    int  m_ocnt;
    int  m_opeak;

    task automatic model(input bit r, input bit v, input int d,
                         input bit fl, input bit rdy);
        int s;
        int p;
        if (r) begin
            m_blk.delete();
            m_hold  = 0;
            m_valid = 0;
            m_osum  = 0;
            m_ocnt  = 0;
            m_opeak = 0;
            return;
        end
        if (!m_hold) begin
            if (v) m_blk.push_back(d);
            if (m_blk.size() == BLK || (fl && m_blk.size() > 0)) begin
                s = 0;
                p = 0;
                foreach (m_blk[i]) begin
                    s += m_blk[i];
                    if (m_blk[i] > p) p = m_blk[i];
                end
                m_osum  = s;
                m_ocnt  = m_blk.size();
                m_opeak = p;
                m_blk.delete();
                m_hold  = 1;
                m_valid = 1;
            end
        end else if (m_valid && rdy) begin
            m_hold  = 0;
            m_valid = 0;
        end
    endtask

    task automatic step(input bit r, input bit v, input int d,
                        input bit fl, input bit rdy);
        rst       = r;
        sq_valid  = v;
        sq_in     = d[9:0];
        flush     = fl;
        out_ready = rdy;
        model(r, v, d, fl, rdy);
        @(posedge clk);
        #1;
        chk("sq_ready", sq_ready, !m_hold);
        chk("out_valid", out_valid, m_valid);
        chk("out_sum", out_sum, m_osum);
        chk("out_cnt", out_cnt, m_ocnt);
`ifdef SQ_ENERGY_PEAK_EN
        chk("out_peak", out_peak, m_opeak);
`endif
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, rdy);
    endtask

    initial begin
        rst = 1; sq_valid = 0; sq_in = 0; flush = 0; out_ready = 0;

        step(1, 1, 961, 1, 1);
        step(1, 0, 0, 0, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", sq_ready, 1);

        // Full block of full-scale samples, then backpressure.
        for (int i = 0; i < BLK; i++) step(0, 1, 961, 0, 0);
        chk("full_valid", out_valid, 1);
        chk("full_sum", out_sum, 15376);
        chk("full_cnt", out_cnt, 16);
        for (int i = 0; i < 5; i++) step(0, 1, 7, i == 2, 0);
        chk("bp_sum", out_sum, 15376);
        chk("bp_ready", sq_ready, 0);
        step(0, 0, 0, 0, 1);
        chk("rel_valid", out_valid, 0);
        chk("rel_ready", sq_ready, 1);

        // Partial block closed by flush with a coincident sample.
        step(0, 1, 1, 0, 0);
        step(0, 1, 4, 0, 0);
        step(0, 1, 9, 0, 0);
        step(0, 1, 16, 1, 0);
        chk("fl_sum", out_sum, 30);
        chk("fl_cnt", out_cnt, 4);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        chk("fl_empty", out_valid, 0);
        step(0, 0, 0, 0, 1);

        // Gapped sample stream, two blocks of 0..15 squared.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < BLK; i++) begin
                repeat ($urandom_range(0, 3)) idle(0);
                step(0, 1, i * i, 0, 0);
            end
            chk("gap_sum", out_sum, 1240);
            chk("gap_cnt", out_cnt, 16);
            repeat ($urandom_range(0, 2)) idle(0);
            idle(1);
        end

        // Reset mid-block, then a clean block from zero.
        for (int i = 0; i < 7; i++) step(0, 1, 500, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rmid_valid", out_valid, 0);
        for (int i = 0; i < BLK; i++) step(0, 1, 2, 0, 0);
        chk("rmid_sum", out_sum, 32);
        chk("rmid_cnt", out_cnt, 16);
        step(1, 0, 0, 0, 0);
        chk("rhold_valid", out_valid, 0);
        chk("rhold_ready", sq_ready, 1);
        step(0, 1, 3, 1, 0);
        chk("rhold_sum", out_sum, 3);
        idle(1);

`ifdef SQ_ENERGY_PEAK_EN
        step(0, 1, 4, 0, 0);
        step(0, 1, 900, 0, 0);
        step(0, 1, 25, 0, 0);
        step(0, 1, 1, 1, 0);
        chk("peak_a", out_peak, 900);
        idle(1);
        step(0, 1, 9, 0, 0);
        step(0, 1, 49, 0, 0);
        step(0, 1, 16, 1, 0);
        chk("peak_b", out_peak, 49);
        idle(1);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 961),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
